// File: rtl/histo_acq_scheduler.sv
// Ping-pong frame sequencer for the dToF histogram memory.
// Each frame clears the write bank, steers TDC bin events into per-pixel
// increment requests (events -> pixels -> acquisitions), publishes the
// finished bank to the reader and flips to the other bank.
module histo_acq_scheduler #(
    parameter int NB      = 8,
    parameter int PW      = 8,
    parameter int PIXELS  = 200,
    parameter int ACQ_NUM = 4,
    parameter int EVT_NUM = 2,
    parameter int AW      = 1 + PW + NB
) (
    input  logic          clk,
    input  logic          res,
    input  logic          run,
    input  logic          tdc_valid,
    input  logic [NB-1:0] tdc_bin,
    output logic          tdc_ready,
    output logic          clr_en,
    output logic          inc_en,
    output logic [AW-1:0] ram_addr,
    output logic          frame_valid,
    output logic          frame_bank,
    input  logic          rd_done,
    output logic [15:0]   frame_cnt,
    output logic          busy
);

    localparam int EW = (EVT_NUM > 1) ? $clog2(EVT_NUM) : 1;
    localparam int QW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

    localparam logic [PW-1:0] PIX_LAST = PW'(PIXELS - 1);
    localparam logic [EW-1:0] EVT_LAST = EW'(EVT_NUM - 1);
    localparam logic [QW-1:0] ACQ_LAST = QW'(ACQ_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        SWAP  = 2'd3
    } state_t;

    state_t        state, state_d;
    logic          wr_bank, wr_bank_d;
    logic [PW-1:0] pix_cnt, pix_d;   // clear sweep pixel and accumulate pixel
    logic [NB-1:0] bin_cnt, bin_d;   // clear sweep bin
    logic [EW-1:0] evt_cnt, evt_d;
    logic [QW-1:0] acq_cnt, acq_d;

    logic          accept;
    logic          swap_done;

    logic          tdc_ready_d, clr_en_d, inc_en_d, busy_d;
    logic [AW-1:0] ram_addr_d;
    logic          frame_valid_d, frame_bank_d;
    logic [15:0]   frame_cnt_d;

    // State register and sequencing counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of its neighbours, independent of order.
        if (!res) begin
            state   <= IDLE;
            wr_bank <= 1'b0;
            pix_cnt <= '0;
            bin_cnt <= '0;
            evt_cnt <= '0;
            acq_cnt <= '0;
        end else begin
            state   <= state_d;
            wr_bank <= wr_bank_d;
            pix_cnt <= pix_d;
            bin_cnt <= bin_d;
            evt_cnt <= evt_d;
            acq_cnt <= acq_d;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        // NOTE: every signal gets a default up front so no path through the
        // case leaves it unassigned, which would otherwise infer a latch.
        state_d   = state;
        wr_bank_d = wr_bank;
        pix_d     = pix_cnt;
        bin_d     = bin_cnt;
        evt_d     = evt_cnt;
        acq_d     = acq_cnt;
        accept    = 1'b0;
        swap_done = 1'b0;

        unique case (state)
            IDLE: begin
                if (run) begin
                    state_d = CLEAR;
                    pix_d   = '0;
                    bin_d   = '0;
                end
            end

            CLEAR: begin
                if (!run) begin
                    // Abort: the partial bank is swept again on the next start.
                    state_d = IDLE;
                    pix_d   = '0;
                    bin_d   = '0;
                end else if (pix_cnt == PIX_LAST && bin_cnt == '1) begin
                    state_d = ACCUM;
                    pix_d   = '0;
                    bin_d   = '0;
                end else if (bin_cnt == '1) begin
                    bin_d = '0;
                    pix_d = pix_cnt + PW'(1);
                end else begin
                    bin_d = bin_cnt + NB'(1);
                end
            end

            ACCUM: begin
                if (!run) begin
                    // Abort drops the event offered in this cycle as well.
                    state_d = IDLE;
                    pix_d   = '0;
                    evt_d   = '0;
                    acq_d   = '0;
                end else if (tdc_valid) begin
                    accept = 1'b1;
                    if (evt_cnt != EVT_LAST) begin
                        evt_d = evt_cnt + EW'(1);
                    end else begin
                        evt_d = '0;
                        if (pix_cnt != PIX_LAST) begin
                            pix_d = pix_cnt + PW'(1);
                        end else begin
                            pix_d = '0;
                            if (acq_cnt != ACQ_LAST) begin
                                acq_d = acq_cnt + QW'(1);
                            end else begin
                                acq_d   = '0;
                                state_d = SWAP;
                            end
                        end
                    end
                end
            end

            SWAP: begin
                // The reader side is free when idle or releasing this cycle.
                if (!frame_valid || rd_done) begin
                    swap_done = 1'b1;
                    wr_bank_d = ~wr_bank;
                    state_d   = run ? CLEAR : IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the next state so
    // each output lines up with the cycle its state is current.
    always_comb begin
        tdc_ready_d = (state_d == ACCUM);
        clr_en_d    = (state_d == CLEAR);
        inc_en_d    = accept;
        busy_d      = (state_d != IDLE);

        ram_addr_d = '0;
        if (state_d == CLEAR) begin
            ram_addr_d = {wr_bank_d, pix_d, bin_d};
        end else if (accept) begin
            ram_addr_d = {wr_bank, pix_cnt, tdc_bin};
        end

        // A publish in the same cycle as a release keeps the flag high.
        if (swap_done) begin
            frame_valid_d = 1'b1;
        end else if (rd_done) begin
            frame_valid_d = 1'b0;
        end else begin
            frame_valid_d = frame_valid;
        end
        frame_bank_d = swap_done ? wr_bank : frame_bank;
        frame_cnt_d  = swap_done ? frame_cnt + 16'd1 : frame_cnt;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!res) begin
            tdc_ready   <= 1'b0;
            clr_en      <= 1'b0;
            inc_en      <= 1'b0;
            ram_addr    <= '0;
            frame_valid <= 1'b0;
            frame_bank  <= 1'b0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
        end else begin
            tdc_ready   <= tdc_ready_d;
            clr_en      <= clr_en_d;
            inc_en      <= inc_en_d;
            ram_addr    <= ram_addr_d;
            frame_valid <= frame_valid_d;
            frame_bank  <= frame_bank_d;
            frame_cnt   <= frame_cnt_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_histo_acq_scheduler.sv
// Directed bench for histo_acq_scheduler with a small geometry:
// NB=2, PW=2, PIXELS=3, ACQ_NUM=2, EVT_NUM=2 (12 words per bank).
module tb_histo_acq_scheduler;

    logic       clk;
    logic       res;
    logic       run;
    logic       tdc_valid;
    logic [1:0] tdc_bin;
    logic       tdc_ready;
    logic       clr_en;
    logic       inc_en;
    logic [4:0] ram_addr;
    logic       frame_valid;
    logic       frame_bank;
    logic       rd_done;
    logic [15:0] frame_cnt;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-event inc addresses of one frame in bank 0 with tdc_bin = 3.
    int ord_addr [12] = '{3, 3, 7, 7, 11, 11, 3, 3, 7, 7, 11, 11};

    histo_acq_scheduler #(
        .NB(2), .PW(2), .PIXELS(3), .ACQ_NUM(2), .EVT_NUM(2), .AW(5)
    ) dut (
        .clk         (clk),
        .res         (res),
        .run         (run),
        .tdc_valid   (tdc_valid),
        .tdc_bin     (tdc_bin),
        .tdc_ready   (tdc_ready),
        .clr_en      (clr_en),
        .inc_en      (inc_en),
        .ram_addr    (ram_addr),
        .frame_valid (frame_valid),
        .frame_bank  (frame_bank),
        .rd_done     (rd_done),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " tdc_ready"},   32'(tdc_ready),   0);
        chk({tag, " clr_en"},      32'(clr_en),      0);
        chk({tag, " inc_en"},      32'(inc_en),      0);
        chk({tag, " ram_addr"},    32'(ram_addr),    0);
        chk({tag, " frame_valid"}, 32'(frame_valid), 0);
        chk({tag, " frame_bank"},  32'(frame_bank),  0);
        chk({tag, " frame_cnt"},   32'(frame_cnt),   0);
        chk({tag, " busy"},        32'(busy),        0);
    endtask

    // Finish the remaining 11 clear cycles of a bank, then enter ACCUM.
    task automatic finish_clear(input int bank_base);
        for (int i = 1; i < 12; i++) begin
            tick();
            chk("clr addr", 32'(ram_addr), 32'(bank_base + i));
        end
        tick();
        chk("clr->accum ready", 32'(tdc_ready), 1);
    endtask

    // Feed one complete frame of 12 events with tdc_bin = 3.
    task automatic feed_frame(input int bank_base);
        tdc_valid = 1'b1;
        tdc_bin   = 2'd3;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("inc_en", 32'(inc_en), 1);
            chk("inc addr", 32'(ram_addr), 32'(bank_base + ord_addr[k]));
        end
        tdc_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        res       = 1'b0;
        run       = 1'b0;
        tdc_valid = 1'b0;
        tdc_bin   = 2'd0;
        rd_done   = 1'b0;
        tick();
        tick();
        chk_reset("reset");

        // 1. Clear sweep of bank 0.
        res = 1'b1;
        run = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk("t1 clr_en", 32'(clr_en), 1);
            chk("t1 clr addr", 32'(ram_addr), 32'(i));
            chk("t1 ready low", 32'(tdc_ready), 0);
            tick();
        end
        chk("t1 ready", 32'(tdc_ready), 1);
        chk("t1 clr_en off", 32'(clr_en), 0);

        // 2. Address ordering, then publish of bank 0.
        feed_frame(0);
        chk("t2 ready in swap", 32'(tdc_ready), 0);
        tick();
        chk("t2 frame_valid", 32'(frame_valid), 1);
        chk("t2 frame_bank", 32'(frame_bank), 0);
        chk("t2 frame_cnt", 32'(frame_cnt), 1);
        chk("t2 next clr bank1", 32'(ram_addr), 16);
        chk("t2 inc_en off", 32'(inc_en), 0);

        // 3. Bank 1 frame completes while bank 0 is still held by the reader.
        finish_clear(16);
        feed_frame(16);
        tick();
        tick();
        tick();
        chk("t3 held ready", 32'(tdc_ready), 0);
        chk("t3 held busy", 32'(busy), 1);
        chk("t3 held clr_en", 32'(clr_en), 0);
        chk("t3 held frame_cnt", 32'(frame_cnt), 1);
        chk("t3 held frame_bank", 32'(frame_bank), 0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("t3 frame_valid", 32'(frame_valid), 1);
        chk("t3 frame_bank", 32'(frame_bank), 1);
        chk("t3 frame_cnt", 32'(frame_cnt), 2);
        chk("t3 next clr bank0", 32'(ram_addr), 0);

        // 4. rd_done in the first SWAP cycle: no stall, flag stays high.
        finish_clear(0);
        feed_frame(0);
        chk("t4 fv before", 32'(frame_valid), 1);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("t4 frame_valid", 32'(frame_valid), 1);
        chk("t4 frame_bank", 32'(frame_bank), 0);
        chk("t4 frame_cnt", 32'(frame_cnt), 3);
        chk("t4 no stall clr", 32'(clr_en), 1);
        chk("t4 clr bank1", 32'(ram_addr), 16);

        // 5. Abort after 5 events; the reader releases bank 0 first.
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("t5 released", 32'(frame_valid), 0);
        for (int i = 2; i < 12; i++) tick();
        tick();
        chk("t5 ready", 32'(tdc_ready), 1);
        tdc_valid = 1'b1;
        tdc_bin   = 2'd1;
        for (int k = 0; k < 5; k++) tick();
        chk("t5 5th addr", 32'(ram_addr), 16 + 8 + 1);
        run       = 1'b0;
        tdc_valid = 1'b0;
        tick();
        chk("t5 busy", 32'(busy), 0);
        chk("t5 ready", 32'(tdc_ready), 0);
        chk("t5 inc_en", 32'(inc_en), 0);
        chk("t5 frame_valid", 32'(frame_valid), 0);
        chk("t5 frame_cnt", 32'(frame_cnt), 3);
        tick();
        chk("t5 idle fv", 32'(frame_valid), 0);
        run = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk("t5 reclr clr_en", 32'(clr_en), 1);
            chk("t5 reclr addr", 32'(ram_addr), 32'(16 + i));
            tick();
        end
        chk("t5 reclr ready", 32'(tdc_ready), 1);

        // 6. Reset mid-ACCUM with an event pending.
        tdc_valid = 1'b1;
        tdc_bin   = 2'd2;
        tick();
        chk("t6 inc_en", 32'(inc_en), 1);
        chk("t6 addr", 32'(ram_addr), 18);
        res = 1'b0;
        tick();
        chk_reset("t6 reset");
        tick();
        chk_reset("t6 hold");
        res       = 1'b1;
        run       = 1'b0;
        tdc_valid = 1'b0;
        tick();
        chk_reset("t6 idle");
        run = 1'b1;
        tick();
        chk("t6 restart clr_en", 32'(clr_en), 1);
        chk("t6 restart bank0", 32'(ram_addr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
